// File: rtl/cart_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cart_mem_arbiter
//
// Shares one external cartridge SRAM between the Game Boy cartridge bus
// (address already banked by the MBC) and the host loader port. Every access
// uses the same fixed strobe sequence:
//   IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE
// The cart port wins ties. A starvation counter makes sure that a waiting host
// is granted after at most STARVE_LIMIT cart grants in a row.
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   cart_req/we/adr/wdata       cart request (a level, held until cart_ack)
//   cart_rdata, cart_ack        cart read data and one-cycle completion pulse
//   host_req/we/adr/wdata       host request, same rules as the cart port
//   host_rdata, host_ack        host read data and one-cycle completion pulse
//   sram_adr, sram_dout         registered SRAM address and write data
//   sram_doe                    1 = drive sram_dout onto the SRAM data pins
//   sram_din                    SRAM data pins, input side
//   sram_ce_n/we_n/oe_n         registered active-low SRAM strobes
//   busy                        1 while an access is in progress
// ---------------------------------------------------------------------------
module cart_mem_arbiter #(
   parameter int ADR_WIDTH    = 21,
   parameter int WAIT_CYCLES  = 2,   // 1..15
   parameter int STARVE_LIMIT = 4    // 1..15
) (
   input  logic                 clk,
   input  logic                 reset,

   input  logic                 cart_req,
   input  logic                 cart_we,
   input  logic [ADR_WIDTH-1:0] cart_adr,
   input  logic [7:0]           cart_wdata,
   output logic [7:0]           cart_rdata,
   output logic                 cart_ack,

   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADR_WIDTH-1:0] host_adr,
   input  logic [7:0]           host_wdata,
   output logic [7:0]           host_rdata,
   output logic                 host_ack,

   output logic [ADR_WIDTH-1:0] sram_adr,
   output logic [7:0]           sram_dout,
   output logic                 sram_doe,
   input  logic [7:0]           sram_din,
   output logic                 sram_ce_n,
   output logic                 sram_we_n,
   output logic                 sram_oe_n,
   output logic                 busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE
   } state_t;

   localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t                 state;
   logic [3:0]             wcnt;
   logic [3:0]             starve_cnt;
   logic                   owner_host;
   logic                   owner_we;

   logic                   starved;
   logic                   grant_cart;
   logic                   grant_host;
   logic                   sel_we;
   logic [ADR_WIDTH-1:0]   sel_adr;
   logic [7:0]             sel_wdata;

   // Grant decision, only acted upon in IDLE. The starvation rule overrides
   // the normal cart priority once the host has waited long enough.
   assign starved    = host_req && (starve_cnt == STARVE_MAX);
   assign grant_cart = cart_req && !starved;
   assign grant_host = host_req && !grant_cart;

   assign sel_we    = grant_host ? host_we    : cart_we;
   assign sel_adr   = grant_host ? host_adr   : cart_adr;
   assign sel_wdata = grant_host ? host_wdata : cart_wdata;

   // busy comes straight from the state register, so it is glitch-free.
   assign busy = (state != ST_IDLE);

   // The strobes are assigned at the same edge that enters the matching state,
   // so each one is a flop output that lines up exactly with its state.
   // NOTE: every assignment in this clocked block is non-blocking, so all
   // registers update together from values sampled before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         wcnt       <= '0;
         starve_cnt <= '0;
         owner_host <= 1'b0;
         owner_we   <= 1'b0;
         sram_adr   <= '0;
         sram_dout  <= '0;
         sram_doe   <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         cart_rdata <= '0;
         host_rdata <= '0;
         cart_ack   <= 1'b0;
         host_ack   <= 1'b0;
      end else begin
         // Acks are single-cycle pulses: cleared every cycle unless ACCESS
         // finishes below.
         cart_ack <= 1'b0;
         host_ack <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (grant_cart || grant_host) begin
                  owner_host <= grant_host;
                  owner_we   <= sel_we;
                  sram_adr   <= sel_adr;
                  sram_dout  <= sel_wdata;
                  sram_ce_n  <= 1'b0;
                  sram_doe   <= sel_we;     // writes drive data from SETUP on
                  sram_oe_n  <= sel_we;     // reads enable outputs from SETUP on
                  state      <= ST_SETUP;
               end
               // Count cart grants that overtake a waiting host.
               if (grant_host || !host_req) begin
                  starve_cnt <= '0;
               end else if (grant_cart && (starve_cnt != STARVE_MAX)) begin
                  starve_cnt <= starve_cnt + 4'd1;
               end
            end

            ST_SETUP: begin
               wcnt      <= '0;
               sram_we_n <= !owner_we;
               state     <= ST_ACCESS;
            end

            ST_ACCESS: begin
               if (wcnt == WAIT_LAST) begin
                  sram_we_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  // Writes keep chip enable (and doe) through DONE for hold time.
                  sram_ce_n <= !owner_we;
                  if (!owner_we) begin
                     if (owner_host) host_rdata <= sram_din;
                     else            cart_rdata <= sram_din;
                  end
                  if (owner_host) host_ack <= 1'b1;
                  else            cart_ack <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end

            ST_DONE: begin
               sram_ce_n <= 1'b1;
               sram_doe  <= 1'b0;
               state     <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cart_mem_arbiter
//
// Directed tests of cart_mem_arbiter (read, write, tie break, starvation
// guard, reset mid-access) followed by a randomised two-requester run that
// checks strobe invariants, ack pairing, latency and data on every access.
// ---------------------------------------------------------------------------
module tb_cart_mem_arbiter;

   localparam int AW = 21;

   logic          clk;
   logic          reset;
   logic          cart_req, cart_we;
   logic [AW-1:0] cart_adr;
   logic [7:0]    cart_wdata, cart_rdata;
   logic          cart_ack;
   logic          host_req, host_we;
   logic [AW-1:0] host_adr;
   logic [7:0]    host_wdata, host_rdata;
   logic          host_ack;
   logic [AW-1:0] sram_adr;
   logic [7:0]    sram_dout, sram_din;
   logic          sram_doe, sram_ce_n, sram_we_n, sram_oe_n;
   logic          busy;

   cart_mem_arbiter #(
      .ADR_WIDTH    (AW),
      .WAIT_CYCLES  (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cart_req   (cart_req),
      .cart_we    (cart_we),
      .cart_adr   (cart_adr),
      .cart_wdata (cart_wdata),
      .cart_rdata (cart_rdata),
      .cart_ack   (cart_ack),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_adr   (host_adr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .host_ack   (host_ack),
      .sram_adr   (sram_adr),
      .sram_dout  (sram_dout),
      .sram_doe   (sram_doe),
      .sram_din   (sram_din),
      .sram_ce_n  (sram_ce_n),
      .sram_we_n  (sram_we_n),
      .sram_oe_n  (sram_oe_n),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-test observation log, stepped once per clock by watch().
   int            step, oe_lo, we_lo, ce_lo, doe_hi;
   int            cack_at, hack_at, cack_n, hack_n, cack_before_h;
   bit            cart_sticky;
   logic [AW-1:0] adr_log [0:63];

   task automatic clear_log();
      step = 0; oe_lo = 0; we_lo = 0; ce_lo = 0; doe_hi = 0;
      cack_at = -1; hack_at = -1; cack_n = 0; hack_n = 0; cack_before_h = -1;
      for (int i = 0; i < 64; i++) adr_log[i] = '0;
   endtask

   // Run n clocks, logging strobes and acks; requesters drop req on their ack
   // (the cart keeps it high while cart_sticky is set).
   task automatic watch(input int n);
      repeat (n) begin
         tick();
         step++;
         if (!sram_oe_n) oe_lo++;
         if (!sram_we_n) we_lo++;
         if (!sram_ce_n) ce_lo++;
         if (sram_doe)   doe_hi++;
         if (step < 64) adr_log[step] = sram_adr;
         if (cart_ack) begin
            if (cack_at < 0) cack_at = step;
            cack_n++;
            if (!cart_sticky) cart_req = 1'b0;
         end
         if (host_ack) begin
            if (hack_at < 0) begin
               hack_at = step;
               cack_before_h = cack_n;
            end
            hack_n++;
            host_req = 1'b0;
         end
      end
   endtask

   // Random-phase state
   bit            cp, hp;
   int            cage, hage, c_iss, c_ack, h_iss, h_ack;
   logic          c_we_l, h_we_l;
   logic [AW-1:0] c_adr_l, h_adr_l;
   logic [7:0]    c_wd_l, h_wd_l, c_exp_rd, h_exp_rd, last_din;

   initial begin
      reset = 1'b1;
      cart_req = 0; cart_we = 0; cart_adr = '0; cart_wdata = '0;
      host_req = 0; host_we = 0; host_adr = '0; host_wdata = '0;
      sram_din = '0;
      cart_sticky = 0;
      clear_log();
      tick(); tick();

      // ---- reset state ----
      check("rst_ce_n",  32'(sram_ce_n), 32'd1);
      check("rst_we_n",  32'(sram_we_n), 32'd1);
      check("rst_oe_n",  32'(sram_oe_n), 32'd1);
      check("rst_doe",   32'(sram_doe),  32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_acks",  32'({cart_ack, host_ack}), 32'd0);
      check("rst_adr",   32'(sram_adr),  32'd0);
      check("rst_dout",  32'(sram_dout), 32'd0);
      check("rst_rdata", 32'({cart_rdata, host_rdata}), 32'd0);
      reset = 1'b0;
      tick();

      // ---- 1: cart read ----
      clear_log();
      cart_req = 1; cart_we = 0; cart_adr = 21'h04123; sram_din = 8'hA5;
      watch(1);
      check("t1_busy",  32'(busy), 32'd1);
      cart_adr = 21'h00000;                 // must be ignored mid-access
      watch(4);
      check("t1_oe_lo",  32'(oe_lo),   32'd3);
      check("t1_we_lo",  32'(we_lo),   32'd0);
      check("t1_ce_lo",  32'(ce_lo),   32'd3);
      check("t1_doe",    32'(doe_hi),  32'd0);
      check("t1_ack_at", 32'(cack_at), 32'd4);
      check("t1_ack_n",  32'(cack_n),  32'd1);
      check("t1_hack_n", 32'(hack_n),  32'd0);
      check("t1_adr",    32'(adr_log[3]), 32'h04123);
      check("t1_rdata",  32'(cart_rdata), 32'hA5);
      check("t1_idle",   32'(busy), 32'd0);

      // ---- 2: host write ----
      clear_log();
      host_req = 1; host_we = 1; host_adr = 21'h1FFFF; host_wdata = 8'h3C; sram_din = 8'h77;
      watch(1);
      host_adr = 21'h00000; host_wdata = 8'h00;   // must be ignored mid-access
      watch(4);
      check("t2_we_lo",  32'(we_lo),   32'd2);
      check("t2_oe_lo",  32'(oe_lo),   32'd0);
      check("t2_doe",    32'(doe_hi),  32'd4);
      check("t2_ce_lo",  32'(ce_lo),   32'd4);
      check("t2_ack_at", 32'(hack_at), 32'd4);
      check("t2_cack_n", 32'(cack_n),  32'd0);
      for (int i = 1; i <= 4; i++) check("t2_adr_stable", 32'(adr_log[i]), 32'h1FFFF);
      check("t2_dout",   32'(sram_dout),  32'h3C);
      check("t2_hrdata", 32'(host_rdata), 32'h00);
      check("t2_crdata", 32'(cart_rdata), 32'hA5);

      // ---- 3: simultaneous requests ----
      clear_log();
      cart_req = 1; cart_we = 0; cart_adr = 21'h00010;
      host_req = 1; host_we = 0; host_adr = 21'h00020;
      sram_din = 8'h5A;
      watch(10);
      check("t3_cack_at", 32'(cack_at), 32'd4);
      check("t3_hack_at", 32'(hack_at), 32'd9);
      check("t3_cack_n",  32'(cack_n),  32'd1);
      check("t3_hack_n",  32'(hack_n),  32'd1);
      check("t3_cadr",    32'(adr_log[1]), 32'h00010);
      check("t3_hadr",    32'(adr_log[6]), 32'h00020);
      check("t3_crdata",  32'(cart_rdata), 32'h5A);
      check("t3_hrdata",  32'(host_rdata), 32'h5A);

      // ---- 4: starvation guard ----
      clear_log();
      cart_sticky = 1;
      cart_req = 1; cart_we = 0; cart_adr = 21'h00100;
      host_req = 1; host_we = 0; host_adr = 21'h00200;
      watch(30);
      cart_sticky = 0;
      cart_req = 0;
      check("t4_cart_first", 32'(cack_before_h), 32'd4);
      check("t4_hack_at",    32'(hack_at), 32'd24);
      check("t4_hack_n",     32'(hack_n),  32'd1);
      check("t4_cack_n",     32'(cack_n),  32'd5);
      watch(6);
      check("t4_idle",   32'(busy), 32'd0);
      check("t4_starve", 32'(dut.starve_cnt), 32'd0);

      // ---- 5: reset during the ACCESS cycle of a write ----
      clear_log();
      host_req = 1; host_we = 1; host_adr = 21'h00055; host_wdata = 8'h99;
      watch(2);
      check("t5_pre_we_n", 32'(sram_we_n), 32'd0);
      reset = 1'b1;
      watch(1);
      check("t5_we_n",   32'(sram_we_n), 32'd1);
      check("t5_ce_n",   32'(sram_ce_n), 32'd1);
      check("t5_doe",    32'(sram_doe),  32'd0);
      check("t5_busy",   32'(busy),      32'd0);
      check("t5_ack",    32'({cart_ack, host_ack}), 32'd0);
      check("t5_rdata",  32'({cart_rdata, host_rdata}), 32'd0);
      reset = 1'b0;
      host_req = 0;
      watch(3);
      check("t5_no_ack", 32'(hack_n), 32'd0);

      // ---- 6: randomised traffic ----
      cp = 0; hp = 0; cage = 0; hage = 0;
      c_iss = 0; c_ack = 0; h_iss = 0; h_ack = 0;
      c_exp_rd = 8'h00; h_exp_rd = 8'h00;
      c_we_l = 0; h_we_l = 0; c_adr_l = '0; h_adr_l = '0; c_wd_l = '0; h_wd_l = '0;
      last_din = '0;
      for (int i = 0; i < 10060; i++) begin
         tick();
         last_din = sram_din;   // value that was on the pins during the previous cycle
         check("r_we_oe",   32'(sram_we_n | sram_oe_n), 32'd1);
         check("r_doe_oe",  32'(sram_doe & !sram_oe_n), 32'd0);
         check("r_ack_one", 32'(cart_ack & host_ack),   32'd0);
         if (cart_ack) begin
            check("r_c_pending", 32'(cp), 32'd1);
            check("r_c_latency", 32'(cage <= 40), 32'd1);
            check("r_c_adr", 32'(sram_adr), 32'(c_adr_l));
            if (c_we_l) check("r_c_wdata", 32'(sram_dout), 32'(c_wd_l));
            else        c_exp_rd = last_din;
            check("r_c_rdata", 32'(cart_rdata), 32'(c_exp_rd));
            cp = 0; c_ack++; cart_req = 0;
         end
         if (host_ack) begin
            check("r_h_pending", 32'(hp), 32'd1);
            check("r_h_latency", 32'(hage <= 40), 32'd1);
            check("r_h_adr", 32'(sram_adr), 32'(h_adr_l));
            if (h_we_l) check("r_h_wdata", 32'(sram_dout), 32'(h_wd_l));
            else        h_exp_rd = last_din;
            check("r_h_rdata", 32'(host_rdata), 32'(h_exp_rd));
            hp = 0; h_ack++; host_req = 0;
         end
         if (cp) cage++;
         if (hp) hage++;
         if (!cp && i < 9900 && $urandom_range(3) == 0) begin
            cp = 1; cage = 0; c_iss++;
            c_we_l = 1'($urandom_range(1)); c_adr_l = 21'($urandom); c_wd_l = 8'($urandom);
            cart_req = 1; cart_we = c_we_l; cart_adr = c_adr_l; cart_wdata = c_wd_l;
         end
         if (!hp && i < 9900 && $urandom_range(3) == 0) begin
            hp = 1; hage = 0; h_iss++;
            h_we_l = 1'($urandom_range(1)); h_adr_l = 21'($urandom); h_wd_l = 8'($urandom);
            host_req = 1; host_we = h_we_l; host_adr = h_adr_l; host_wdata = h_wd_l;
         end
         sram_din = 8'($urandom);
      end
      check("r_c_drained", 32'(cp), 32'd0);
      check("r_h_drained", 32'(hp), 32'd0);
      check("r_c_pairs",   32'(c_ack), 32'(c_iss));
      check("r_h_pairs",   32'(h_ack), 32'(h_iss));
      check("r_final_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
